// File: rtl/mult_div_pkg.sv
// Shared constants and state encoding for the multicycle multiply/divide unit.
package mult_div_pkg;

  // Default operand width; Hi and Lo are each this wide.
  localparam int DATA_W_DEF = 32;

  // One Booth or restoring step per cycle, one step per operand bit.
  localparam int STEPS = DATA_W_DEF;

  // Step counter width; it is cleared at every accepted start.
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step on unsigned magnitudes: shift the next dividend
// bit into the partial remainder, trial-subtract the divisor, keep the
// difference when it does not borrow, and shift the outcome into the quotient.
module div_restore_step
  import mult_div_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quot,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quot_next
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;
  logic            fits;

  // The partial remainder is always below the divisor magnitude (at most
  // 2^(DATA_W-1)), so one extra bit is enough for the shifted value and
  // the top bit of the trial difference is the borrow.
  assign shifted   = {rem, quot[DATA_W-1]};
  assign trial     = shifted - {1'b0, divisor};
  assign fits      = ~trial[DATA_W];
  assign rem_next  = fits ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign quot_next = {quot[DATA_W-2:0], fits};

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply / divide unit. Multiply is radix-2 Booth, divide
// is restoring division on magnitudes with sign fix-up; both take DATA_W
// single-bit steps. Results are registered into hi/lo on the final step and
// presented with a one-cycle done pulse.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int DATA_W = STEPS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_mult,
  input  logic              start_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_zero
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  // Magnitude of a two's-complement value; the most negative value maps to
  // its correct unsigned magnitude 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
    logic [DATA_W-1:0] u;
    u = v;
    return u[DATA_W-1] ? (~u + DATA_W'(1)) : u;
  endfunction

  // Re-apply a sign to an unsigned magnitude.
  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] m,
                                                   input logic neg);
    return neg ? (~m + DATA_W'(1)) : m;
  endfunction

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               last_step;
  logic               b_zero;

  // Booth datapath: acc = {P_hi, P_lo, q-1}
  logic [2*DATA_W:0]        acc;
  logic [2*DATA_W:0]        acc_nxt;
  logic signed [DATA_W-1:0] mcand;
  logic signed [DATA_W:0]   p_hi_x;
  logic signed [DATA_W:0]   mcand_x;
  logic signed [DATA_W:0]   booth_sum;

  // Divide datapath
  logic [DATA_W-1:0] rem, quot, dvsr;
  logic [DATA_W-1:0] rem_nxt, quot_nxt;
  logic              q_neg, r_neg;

  assign last_step = (cnt == LAST_STEP);
  assign b_zero    = (b == '0);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; multiply wins over divide, starts are ignored while busy.
  // A zero divisor still passes through DIV for one cycle so that done
  // appears one cycle after the start edge.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_mult)     state_nxt = ST_MULT;
        else if (start_div) state_nxt = ST_DIV;
      end
      ST_MULT: if (last_step) state_nxt = ST_DONE;
      ST_DIV:  if (div_zero || last_step) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Booth step. The add/subtract is done one bit wider than P_hi so that a
  // most-negative multiplicand cannot overflow; the extra bit becomes the
  // sign shifted in by the arithmetic right shift.
  assign p_hi_x  = {acc[2*DATA_W], acc[2*DATA_W:DATA_W+1]};
  assign mcand_x = {mcand[DATA_W-1], mcand};

  // Select add, subtract or pass-through from the Booth bit pair.
  always_comb begin
    booth_sum = p_hi_x;
    case (acc[1:0])
      2'b01:   booth_sum = p_hi_x + mcand_x;
      2'b10:   booth_sum = p_hi_x - mcand_x;
      default: booth_sum = p_hi_x;
    endcase
    acc_nxt = {booth_sum, acc[DATA_W:1]};
  end

  div_restore_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem       (rem),
    .quot      (quot),
    .divisor   (dvsr),
    .rem_next  (rem_nxt),
    .quot_next (quot_nxt)
  );

  // Working registers: loaded at an accepted start, stepped while iterating.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start_mult) begin
      acc   <= {{DATA_W{1'b0}}, b, 1'b0};
      mcand <= a;
    end else if (state == ST_MULT) begin
      acc   <= acc_nxt;
    end

    if (state == ST_IDLE && !start_mult && start_div && !b_zero) begin
      rem   <= '0;
      quot  <= mag(a);
      dvsr  <= mag(b);
      q_neg <= a[DATA_W-1] ^ b[DATA_W-1];
      r_neg <= a[DATA_W-1];
    end else if (state == ST_DIV) begin
      rem   <= rem_nxt;
      quot  <= quot_nxt;
    end
  end

  // Step counter, result registers and divide-by-zero flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        if (start_mult || start_div) cnt <= '0;
        if (start_mult)     div_zero <= 1'b0;
        else if (start_div) div_zero <= b_zero;
      end else if (state == ST_MULT || state == ST_DIV) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (state == ST_MULT && last_step) begin
        hi <= acc_nxt[2*DATA_W:DATA_W+1];
        lo <= acc_nxt[DATA_W:1];
      end else if (state == ST_DIV && last_step && !div_zero) begin
        hi <= apply_sign(rem_nxt, r_neg);
        lo <= apply_sign(quot_nxt, q_neg);
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: multiply/divide vectors with
// hand-computed results, latency, divide-by-zero, ignored starts and an
// asynchronous reset in the middle of a divide.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int passed;
  int total;

  mult_div_unit #(.DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .div_zero   (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one start, then count edges after the start edge until done.
  // lat = -1 if done never arrives. Optionally pulses start_div before edge
  // number pulse_at.
  task automatic run_op(input logic m, input logic d, input logic [31:0] aa,
                        input logic [31:0] bb, input int pulse_at,
                        output int lat, output logic busy_ok);
    @(posedge clk); #1;
    start_mult = m; start_div = d; a = aa; b = bb;
    @(posedge clk); #1;
    start_mult = 1'b0; start_div = 1'b0;
    lat = -1;
    busy_ok = busy;
    for (int k = 1; k <= 40; k++) begin
      if (k == pulse_at) start_div = 1'b1;
      @(posedge clk); #1;
      start_div = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  int   lat;
  logic bok;
  logic saw_done;

  initial begin
    passed = 0; total = 0;
    reset = 1'b0; start_mult = 1'b0; start_div = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz",   64'(div_zero), 64'd0);
    chk("rst_hi",   64'(hi), 64'd0);
    chk("rst_lo",   64'(lo), 64'd0);
    reset = 1'b1;

    // 7 * -3 = -21
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, -1, lat, bok);
    chk("m1_lat",  64'(lat), 64'd32);
    chk("m1_busy", 64'(bok), 64'd1);
    chk("m1_hi",   64'(hi), 64'hFFFFFFFF);
    chk("m1_lo",   64'(lo), 64'hFFFFFFEB);
    chk("m1_dz",   64'(div_zero), 64'd0);
    @(posedge clk); #1;
    chk("m1_done_1cyc", 64'(done), 64'd0);
    chk("m1_idle",      64'(busy), 64'd0);
    chk("m1_hold_lo",   64'(lo), 64'hFFFFFFEB);

    // (2^31-1)^2
    run_op(1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, -1, lat, bok);
    chk("m2_lat", 64'(lat), 64'd32);
    chk("m2_hi",  64'(hi), 64'h3FFFFFFF);
    chk("m2_lo",  64'(lo), 64'h00000001);

    // (-2^31)^2 = 2^62
    run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, -1, lat, bok);
    chk("m3_hi", 64'(hi), 64'h40000000);
    chk("m3_lo", 64'(lo), 64'h00000000);

    // -7 / 2 -> q=-3, r=-1
    run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, -1, lat, bok);
    chk("d1_lat",  64'(lat), 64'd32);
    chk("d1_busy", 64'(bok), 64'd1);
    chk("d1_lo",   64'(lo), 64'hFFFFFFFD);
    chk("d1_hi",   64'(hi), 64'hFFFFFFFF);
    chk("d1_dz",   64'(div_zero), 64'd0);

    // 7 / -2 -> q=-3, r=1
    run_op(1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, -1, lat, bok);
    chk("d2_lo", 64'(lo), 64'hFFFFFFFD);
    chk("d2_hi", 64'(hi), 64'h00000001);

    // -7 / -2 -> q=3, r=-1
    run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, -1, lat, bok);
    chk("d3_lo", 64'(lo), 64'h00000003);
    chk("d3_hi", 64'(hi), 64'hFFFFFFFF);

    // most negative / -1
    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, -1, lat, bok);
    chk("d4_lo", 64'(lo), 64'h80000000);
    chk("d4_hi", 64'(hi), 64'h00000000);
    chk("d4_dz", 64'(div_zero), 64'd0);

    // 5 / 0: one-cycle latency, flag set, results untouched
    run_op(1'b0, 1'b1, 32'd5, 32'd0, -1, lat, bok);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_dz",  64'(div_zero), 64'd1);
    chk("dz_lo",  64'(lo), 64'h80000000);
    chk("dz_hi",  64'(hi), 64'h00000000);
    @(posedge clk); #1;
    chk("dz_done_1cyc", 64'(done), 64'd0);
    chk("dz_held",      64'(div_zero), 64'd1);

    // start_div pulsed at E5 of a multiply: ignored
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 5, lat, bok);
    chk("ign_lat", 64'(lat), 64'd32);
    chk("ign_hi",  64'(hi), 64'hFFFFFFFF);
    chk("ign_lo",  64'(lo), 64'hFFFFFFEB);
    chk("ign_dz",  64'(div_zero), 64'd0);
    @(posedge clk); #1;
    chk("ign_idle", 64'(busy), 64'd0);

    // both starts: multiply -7 * 2 = -14 (divide would give -3 / -1)
    run_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, -1, lat, bok);
    chk("both_lat", 64'(lat), 64'd32);
    chk("both_hi",  64'(hi), 64'hFFFFFFFF);
    chk("both_lo",  64'(lo), 64'hFFFFFFF2);

    // asynchronous reset at E10 of a divide
    @(posedge clk); #1;
    start_div = 1'b1; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start_div = 1'b0;
    saw_done = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("ab_busy_pre", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_hi",   64'(hi), 64'd0);
    chk("ab_lo",   64'(lo), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    reset = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("ab_no_done", 64'(saw_done), 64'd0);
    chk("ab_lo_kept", 64'(lo), 64'd0);

    // fresh multiply after reset: 0x12345678 * 16
    run_op(1'b1, 1'b0, 32'h12345678, 32'h00000010, -1, lat, bok);
    chk("post_lat", 64'(lat), 64'd32);
    chk("post_hi",  64'(hi), 64'h00000001);
    chk("post_lo",  64'(lo), 64'h23456780);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multicycle signed multiply/divide unit for the MIPS datapath. It sits directly downstream of the control FSM, which pulses `start_mult` or `start_div` for `mult` or `div` and then waits on `done`. Operands come from registers A/B, and results land in the Hi/Lo inputs selected by the datapath mux. A divide-by-zero flag is returned so the FSM can enter exception handling.

## Interface
- `DATA_W`, default 32: operand width; Hi and Lo are each `DATA_W` bits.
- `clk`  in  1: clock, rising-edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start_mult`  in  1: request a signed multiply; sampled only in IDLE.
- `start_div`  in  1: request a signed divide; sampled only in IDLE.
- `a`  in  DATA_W: multiplicand or dividend (reg A); latched at start.
- `b`  in  DATA_W: multiplier or divisor (reg B); latched at start.
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  1: one-cycle pulse; `hi`/`lo`/`div_zero` are valid in this cycle.
- `hi`  out  DATA_W: mult upper product; div remainder.
- `lo`  out  DATA_W: mult lower product; div quotient.
- `div_zero`  out  1: divisor was 0; valid with `done`, held until the next accepted start.

## Operation
- States: IDLE, MULT, DIV, DONE.
- **IDLE**
  - `start_mult` → latch operands, clear 6-bit counter, go to MULT.
  - `start_div` with b ≠ 0 → latch operands, go to DIV.
  - `start_div` with b = 0 → set `div_zero`, go to DONE; hi/lo are unchanged.
  - Both starts high → multiply wins; divide is ignored.
- **MULT**
  - Radix-2 Booth, one step per cycle, 32 steps.
  - 65-bit accumulator {P_hi, P_lo, q-1}; arithmetic right shift.
  - Result is the full signed 64-bit product: hi = [63:32], lo = [31:0].
- **DIV**
  - Restoring division on magnitudes, 32 steps.
  - Quotient sign = sign(a) XOR sign(b), truncated toward zero.
  - Remainder takes the sign of the dividend (MIPS semantics).
  - 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0; no flag.
- **DONE**
  - Registered results drive `hi`/`lo`; `done` = 1; `div_zero` cleared unless set by this op.
  - Next edge → IDLE.
- Starts seen while busy are ignored; no queueing.
- `hi`/`lo` hold their last result until the next DONE.
- The counter wraps only through an explicit clear at start; step count is exactly `DATA_W`.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - state = IDLE, counter = 0.
  - `busy`, `done`, `div_zero` = 0; `hi` = `lo` = 0.
- Start sampled at edge E0:
  - `busy` rises after E0.
  - Iterations occur on E1..E32.
  - DONE is entered at E32, so `done` is high in the cycle E32–E33.
  - IDLE at E33; a new start can be accepted at E33.
- Divide by zero: DONE at E1, `done` high for E1–E2.
- `done` never lasts more than one cycle.
- Reset asserted mid-operation:
  - Aborts immediately; outputs take reset values.
  - No `done` pulse for the aborted op.

## Structure
- Package `mult_div_pkg` holds:
  - `DATA_W` default constant.
  - State enum (IDLE, MULT, DIV, DONE) with fixed 2-bit encoding 0..3.
  - Step-count constant.
- Sub-module `div_restore_step` (combinational): one restoring subtract/shift step on {rem, quot}.
  - Instantiated once and reused each cycle.
- The Booth step stays inline.
- Target: about 200–300 lines of RTL total.

## Test plan
- mult a=7, b=0xFFFFFFFD (−3) → `done` at E0+32, hi=0xFFFFFFFF, lo=0xFFFFFFEB, `busy` high for 32 cycles.
- mult a=0x7FFFFFFF, b=0x7FFFFFFF → hi=0x3FFFFFFF, lo=0x00000001; a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0.
- div a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, `div_zero`=0.
- div a=5, b=0 → `done` and `div_zero` high at E0+1; hi/lo keep the previous result.
- `start_div` pulsed at E5 during a mult, and both starts high in IDLE → only the mult runs; its result matches the mult-only reference.
- `reset` low at E10 of a div → `busy`/`hi`/`lo` = 0 asynchronously; no `done`; a fresh mult after release completes normally.
